// File: rtl/fwd_regfile.sv
// fwd_regfile: register file with bypass/forwarding network, load-use
// interlock, exception PC (EPC) register and a stall watchdog.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   rd_valid, use1, use2         decode-stage instruction valid / port usage
//   rd1_sel, rd2_sel             read register selects
//   wr_en, wr_sel, wr_data       writeback port
//   fwd_valid/fwd_sel/fwd_data   per-stage forwarding (stage i in slice i,
//                                stage 0 = execute, highest index = oldest)
//   ex_load                      stage 0 holds a load with no data yet
//   epc_save, epc_data           EPC capture
//   epc_restore                  port 1 returns EPC
//   rd1_data, rd2_data           resolved operands (combinational)
//   stall                        load-use interlock (combinational)
//   err                          sticky error (watchdog fault / link-EPC conflict)
//
// Watchdog states
//   state    | meaning
//   S_RUN    | no stall seen last cycle
//   S_HOLD1  | one consecutive stall cycle seen
//   S_HOLD2  | two consecutive stall cycles seen
//   S_FAULT  | three consecutive stalls; terminal until reset
module fwd_regfile #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int NFWD  = 3,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_valid,
    input  logic [AW-1:0]         rd1_sel,
    input  logic [AW-1:0]         rd2_sel,
    input  logic                  use1,
    input  logic                  use2,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_sel,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [NFWD-1:0]       fwd_valid,
    input  logic [NFWD*AW-1:0]    fwd_sel,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    input  logic                  ex_load,
    input  logic                  epc_save,
    input  logic [WIDTH-1:0]      epc_data,
    input  logic                  epc_restore,
    output logic [WIDTH-1:0]      rd1_data,
    output logic [WIDTH-1:0]      rd2_data,
    output logic                  stall,
    output logic                  err
);

    typedef enum logic [1:0] {S_RUN, S_HOLD1, S_HOLD2, S_FAULT} state_t;

    localparam logic [AW-1:0] LINK_REG = AW'(NREG - 1);

    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH-1:0] r_epc;
    logic             r_err;
    state_t           r_state;

    logic [NFWD-1:0]  w_fwd_ok;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic             w_stall;
    logic             w_link_conflict;

    // Stage 0 carries an address, not a result, while a load is in execute.
    always_comb begin
        w_fwd_ok    = fwd_valid;
        w_fwd_ok[0] = fwd_valid[0] & ~ex_load;
    end

    // Lowest priority first so later assignments win: array, writeback,
    // oldest stage down to stage 0, then EPC on port 1.
    always_comb begin
        w_rd1 = r_regs[rd1_sel];
        w_rd2 = r_regs[rd2_sel];
        if (wr_en && (wr_sel == rd1_sel)) w_rd1 = wr_data;
        if (wr_en && (wr_sel == rd2_sel)) w_rd2 = wr_data;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (w_fwd_ok[i] && (fwd_sel[i*AW +: AW] == rd1_sel)) w_rd1 = fwd_data[i*WIDTH +: WIDTH];
            if (w_fwd_ok[i] && (fwd_sel[i*AW +: AW] == rd2_sel)) w_rd2 = fwd_data[i*WIDTH +: WIDTH];
        end
        if (epc_restore) w_rd1 = r_epc;
    end

    // Port 1 does not need the load result when it is returning EPC.
    assign w_stall = rd_valid & ex_load & fwd_valid[0] &
                     ((use1 & (fwd_sel[AW-1:0] == rd1_sel) & ~epc_restore) |
                      (use2 & (fwd_sel[AW-1:0] == rd2_sel)));

    assign w_link_conflict = wr_en & epc_save & (wr_sel == LINK_REG);

    assign rd1_data = w_rd1;
    assign rd2_data = w_rd2;
    assign stall    = w_stall;
    assign err      = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_epc   <= '0;
            r_err   <= 1'b0;
            r_state <= S_RUN;
        end else begin
            if (wr_en)    r_regs[wr_sel] <= wr_data;
            if (epc_save) r_epc <= epc_data;

            case (r_state)
                S_RUN:   r_state <= w_stall ? S_HOLD1 : S_RUN;
                S_HOLD1: r_state <= w_stall ? S_HOLD2 : S_RUN;
                S_HOLD2: r_state <= w_stall ? S_FAULT : S_RUN;
                default: r_state <= S_FAULT;
            endcase

            // err is registered alongside the transition into FAULT.
            if (w_link_conflict || (r_state == S_HOLD2 && w_stall) || r_state == S_FAULT)
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_regfile.sv
module tb_fwd_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance: WIDTH=16, NREG=8, NFWD=3
    logic        rd_valid, use1, use2, wr_en, ex_load, epc_save, epc_restore;
    logic [2:0]  rd1_sel, rd2_sel, wr_sel;
    logic [15:0] wr_data, epc_data;
    logic [2:0]  fwd_valid;
    logic [8:0]  fwd_sel;
    logic [47:0] fwd_data;
    logic [15:0] rd1_data, rd2_data;
    logic        stall, err;

    // wide instance: WIDTH=32, NREG=16, NFWD=4
    logic        b_rd_valid, b_use1, b_use2, b_wr_en, b_ex_load, b_epc_save, b_epc_restore;
    logic [3:0]  b_rd1_sel, b_rd2_sel, b_wr_sel;
    logic [31:0] b_wr_data, b_epc_data;
    logic [3:0]  b_fwd_valid;
    logic [15:0] b_fwd_sel;
    logic [127:0] b_fwd_data;
    logic [31:0] b_rd1_data, b_rd2_data;
    logic        b_stall, b_err;

    fwd_regfile dut (
        .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
        .use1(use1), .use2(use2), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .fwd_valid(fwd_valid), .fwd_sel(fwd_sel), .fwd_data(fwd_data), .ex_load(ex_load),
        .epc_save(epc_save), .epc_data(epc_data), .epc_restore(epc_restore),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .stall(stall), .err(err)
    );

    fwd_regfile #(.WIDTH(32), .NREG(16), .NFWD(4)) dut_b (
        .clk(clk), .rst(rst), .rd_valid(b_rd_valid), .rd1_sel(b_rd1_sel), .rd2_sel(b_rd2_sel),
        .use1(b_use1), .use2(b_use2), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
        .fwd_valid(b_fwd_valid), .fwd_sel(b_fwd_sel), .fwd_data(b_fwd_data), .ex_load(b_ex_load),
        .epc_save(b_epc_save), .epc_data(b_epc_data), .epc_restore(b_epc_restore),
        .rd1_data(b_rd1_data), .rd2_data(b_rd2_data), .stall(b_stall), .err(b_err)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic idle();
        rd_valid = 0; use1 = 0; use2 = 0; wr_en = 0; ex_load = 0; epc_save = 0; epc_restore = 0;
        rd1_sel = 0; rd2_sel = 0; wr_sel = 0; wr_data = 0; epc_data = 0;
        fwd_valid = 0; fwd_sel = 0; fwd_data = 0;
        b_rd_valid = 0; b_use1 = 0; b_use2 = 0; b_wr_en = 0; b_ex_load = 0; b_epc_save = 0; b_epc_restore = 0;
        b_rd1_sel = 0; b_rd2_sel = 0; b_wr_sel = 0; b_wr_data = 0; b_epc_data = 0;
        b_fwd_valid = 0; b_fwd_sel = 0; b_fwd_data = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stall_cond();
        rd_valid = 1; ex_load = 1; fwd_valid = 3'b001; fwd_sel = {3'd0, 3'd0, 3'd5};
        use2 = 1; rd2_sel = 5;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        rd1_sel = 3; rd2_sel = 3;
        sb.push_back('{"rst_rd1", 32'h0});
        sb.push_back('{"rst_rd2", 32'h0});
        sb.push_back('{"rst_stall", 32'h0});
        sb.push_back('{"rst_err", 32'h0});
        #2;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(stall) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, stall, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        // writes and epc_save during reset must be ignored, bypass still visible
        wr_en = 1; wr_sel = 3; wr_data = 16'hAAAA; epc_save = 1; epc_data = 16'h7777;
        sb.push_back('{"rst_bypass", 32'hAAAA});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        next_cycle();
        next_cycle();
        rst = 0; wr_en = 0; epc_save = 0;
        sb.push_back('{"rst_no_write", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        epc_restore = 1;
        sb.push_back('{"rst_no_epc", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        epc_restore = 0;
    endtask

    task automatic test_write_read();
        next_cycle();
        wr_en = 1; wr_sel = 1; wr_data = 16'h1234; rd1_sel = 1; rd2_sel = 0;
        sb.push_back('{"wr_bypass", 32'h1234});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        next_cycle();
        wr_sel = 6; wr_data = 16'hABCD;
        next_cycle();
        wr_en = 0; rd1_sel = 1; rd2_sel = 6;
        sb.push_back('{"rd_r1", 32'h1234});
        sb.push_back('{"rd_r6", 32'hABCD});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        rd1_sel = 6; rd2_sel = 1;
        sb.push_back('{"rd_swap1", 32'hABCD});
        sb.push_back('{"rd_swap2", 32'h1234});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
    endtask

    task automatic test_fwd_priority();
        next_cycle();
        idle();
        rd1_sel = 2; rd2_sel = 2;
        fwd_valid = 3'b101; fwd_sel = {3'd2, 3'd2, 3'd2};
        fwd_data = {16'h3333, 16'h2222, 16'h1111};
        wr_en = 1; wr_sel = 2; wr_data = 16'h4444;
        sb.push_back('{"fwd_s0_p1", 32'h1111});
        sb.push_back('{"fwd_s0_p2", 32'h1111});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        fwd_valid = 3'b100;
        sb.push_back('{"fwd_s2", 32'h3333});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        fwd_valid = 3'b110;
        sb.push_back('{"fwd_s1_over_s2", 32'h2222});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        fwd_valid = 3'b000;
        sb.push_back('{"fwd_wb", 32'h4444});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        fwd_valid = 3'b101; ex_load = 1;
        sb.push_back('{"fwd_load_skip_s0", 32'h3333});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        fwd_valid = 3'b001;
        sb.push_back('{"fwd_load_to_wb", 32'h4444});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        next_cycle();
        idle();
        rd1_sel = 2;
        sb.push_back('{"fwd_wb_written", 32'h4444});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
    endtask

    task automatic test_load_use();
        next_cycle();
        idle();
        set_stall_cond();
        sb.push_back('{"lu_stall_p2", 32'h1});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(stall) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, stall, e.exp); else n_pass++;
        use2 = 0;
        sb.push_back('{"lu_no_use2", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(stall) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, stall, e.exp); else n_pass++;
        use1 = 1; rd1_sel = 5;
        sb.push_back('{"lu_stall_p1", 32'h1});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(stall) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, stall, e.exp); else n_pass++;
        epc_restore = 1;
        sb.push_back('{"lu_epc_masks", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(stall) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, stall, e.exp); else n_pass++;
        epc_restore = 0; rd_valid = 0;
        sb.push_back('{"lu_no_rd_valid", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(stall) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, stall, e.exp); else n_pass++;
        rd_valid = 1; use1 = 0; use2 = 1;
        next_cycle();
        // load moved to stage 1 with its data
        ex_load = 0; fwd_valid = 3'b010; fwd_sel = {3'd0, 3'd5, 3'd0};
        fwd_data = {16'h0, 16'hBEEF, 16'h0};
        sb.push_back('{"lu_s1_stall", 32'h0});
        sb.push_back('{"lu_s1_data", 32'hBEEF});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(stall) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, stall, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        next_cycle();
        idle();
    endtask

    task automatic test_epc();
        next_cycle();
        epc_save = 1; epc_data = 16'h0042;
        next_cycle();
        epc_save = 0; epc_restore = 1; rd1_sel = 1; rd2_sel = 6;
        sb.push_back('{"epc_rd1", 32'h0042});
        sb.push_back('{"epc_rd2_array", 32'hABCD});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        epc_save = 1; epc_data = 16'h0099;
        sb.push_back('{"epc_coincide_old", 32'h0042});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        next_cycle();
        epc_save = 0;
        sb.push_back('{"epc_coincide_new", 32'h0099});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        idle();
    endtask

    task automatic test_link_conflict();
        next_cycle();
        wr_en = 1; wr_sel = 6; wr_data = 16'h6666; epc_save = 1; epc_data = 16'h0011;
        next_cycle();
        wr_sel = 7; wr_data = 16'h7777; epc_data = 16'h0022;
        sb.push_back('{"link_no_err_r6", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        next_cycle();
        idle();
        rd2_sel = 7; epc_restore = 1;
        sb.push_back('{"link_err", 32'h1});
        sb.push_back('{"link_wr_done", 32'h7777});
        sb.push_back('{"link_epc_done", 32'h0022});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        next_cycle();
        sb.push_back('{"link_sticky", 32'h1});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        rst = 1;
        sb.push_back('{"link_rst_err", 32'h0});
        sb.push_back('{"link_rst_reg", 32'h0});
        #2;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd2_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd2_data, e.exp); else n_pass++;
        next_cycle();
        rst = 0;
        idle();
    endtask

    task automatic test_watchdog();
        next_cycle();
        // two stalls then a break: must not fault
        set_stall_cond();
        next_cycle();
        next_cycle();
        idle();
        next_cycle();
        set_stall_cond();
        next_cycle();
        next_cycle();
        sb.push_back('{"wd_after_break", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        next_cycle();
        sb.push_back('{"wd_fault", 32'h1});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        idle();
        wr_en = 1; wr_sel = 3; wr_data = 16'h3C3C; epc_save = 1; epc_data = 16'h0555;
        next_cycle();
        idle();
        next_cycle();
        rd1_sel = 3;
        sb.push_back('{"wd_err_stays", 32'h1});
        sb.push_back('{"wd_write_in_fault", 32'h3C3C});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        epc_restore = 1;
        sb.push_back('{"wd_epc_in_fault", 32'h0555});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(rd1_data) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rd1_data, e.exp); else n_pass++;
        idle();
        rst = 1;
        next_cycle();
        rst = 0;
        // reach HOLD2, then reset with stall still asserted
        set_stall_cond();
        next_cycle();
        next_cycle();
        rst = 1;
        sb.push_back('{"wd_rst_hold2", 32'h0});
        #2;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        next_cycle();
        rst = 0;
        next_cycle();
        next_cycle();
        sb.push_back('{"wd_run_after_rst", 32'h0});
        #1;
        e = sb.pop_front(); n_chk++; if (32'(err) !== e.exp) $display("FAIL %s: got %h expected %h", e.name, err, e.exp); else n_pass++;
        idle();
        next_cycle();
    endtask

    task automatic test_wide();
        next_cycle();
        b_wr_en = 1; b_wr_sel = 15; b_wr_data = 32'hDEADBEEF;
        next_cycle();
        b_wr_en = 0; b_rd1_sel = 15; b_rd2_sel = 9;
        b_fwd_valid = 4'b1000; b_fwd_sel = {4'd9, 4'd0, 4'd0, 4'd0};
        b_fwd_data = {32'hCAFEF00D, 32'h11111111, 32'h0, 32'h0};
        sb.push_back('{"wide_r15", 32'hDEADBEEF});
        sb.push_back('{"wide_s3", 32'hCAFEF00D});
        #1;
        e = sb.pop_front(); n_chk++; if (b_rd1_data !== e.exp) $display("FAIL %s: got %h expected %h", e.name, b_rd1_data, e.exp); else n_pass++;
        e = sb.pop_front(); n_chk++; if (b_rd2_data !== e.exp) $display("FAIL %s: got %h expected %h", e.name, b_rd2_data, e.exp); else n_pass++;
        b_fwd_valid = 4'b1100; b_fwd_sel = {4'd9, 4'd9, 4'd0, 4'd0};
        sb.push_back('{"wide_s2_over_s3", 32'h11111111});
        #1;
        e = sb.pop_front(); n_chk++; if (b_rd2_data !== e.exp) $display("FAIL %s: got %h expected %h", e.name, b_rd2_data, e.exp); else n_pass++;
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fwd_priority();
        test_load_use();
        test_epc();
        test_link_conflict();
        test_watchdog();
        test_wide();
        n_chk++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
